// File: rtl/regfile_defs.sv
// Shared register-file constants, used by the write bank and the read-mux stage.
package regfile_defs;

  localparam int RF_WIDTH    = 32;
  localparam int RF_AW       = 5;
  localparam int RF_NREGS    = 32;
  localparam int RF_ZERO_REG = 31;

  localparam int RF_COUNT_W  = 16;

endpackage

// File: rtl/reg_en32.sv
// Single architectural register: synchronous active-high reset, load when enabled.
module reg_en32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset clears the register; otherwise it loads d only when its enable is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_write_bank.sv
// Storage half of the register file: holds the registers, decodes the single
// write port and exposes every register value in parallel for the read muxes.
// The zero register is a constant slice, not a flop, so writes to it are lost.
module regfile_write_bank
  import regfile_defs::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int NREGS    = RF_NREGS,
  parameter int AW       = RF_AW,
  parameter int ZERO_REG = RF_ZERO_REG
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   RegWrite,
  input  logic [AW-1:0]          WriteRegister,
  input  logic [WIDTH-1:0]       WriteData,
  output logic [NREGS*WIDTH-1:0] regs_flat,
  output logic                   wr_commit,
  output logic [AW-1:0]          wr_commit_addr,
  output logic [15:0]            write_count
);

  logic [NREGS-1:0] wrEn;
  logic             commitNext;

  // One-hot write decode gated by RegWrite; the zero register never gets an enable.
  always_comb begin
    wrEn = '0;
    if (RegWrite) begin
      wrEn[WriteRegister] = 1'b1;
    end
    wrEn[ZERO_REG] = 1'b0;
  end

  assign commitNext = RegWrite && (WriteRegister != AW'(ZERO_REG));

  // Storage: one enabled register per index, with the zero register tied off.
  // regs_flat is wired straight from the flops so there is no bypass path.
  for (genvar i = 0; i < NREGS; i++) begin : g_regs
    if (i == ZERO_REG) begin : g_zero
      assign regs_flat[i*WIDTH +: WIDTH] = '0;
    end else begin : g_reg
      reg_en32 #(
        .WIDTH(WIDTH)
      ) u_reg (
        .clk  (clk),
        .reset(reset),
        .en   (wrEn[i]),
        .d    (WriteData),
        .q    (regs_flat[i*WIDTH +: WIDTH])
      );
    end
  end

  // Commit status: pulse and address of the last real write plus a wrapping count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_commit      <= 1'b0;
      wr_commit_addr <= '0;
      write_count    <= '0;
    end else begin
      wr_commit <= commitNext;
      if (commitNext) begin
        wr_commit_addr <= WriteRegister;
        write_count    <= write_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Self-checking bench for regfile_write_bank: a table of single-cycle vectors,
// a register walk, a counter-wrap run and a reset-during-write sequence.
module tb_regfile_write_bank;

  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int ZR    = 31;

  logic                   clk;
  logic                   reset;
  logic                   RegWrite;
  logic [AW-1:0]          WriteRegister;
  logic [WIDTH-1:0]       WriteData;
  logic [NREGS*WIDTH-1:0] regs_flat;
  logic                   wr_commit;
  logic [AW-1:0]          wr_commit_addr;
  logic [15:0]            write_count;

  regfile_write_bank dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .regs_flat     (regs_flat),
    .wr_commit     (wr_commit),
    .wr_commit_addr(wr_commit_addr),
    .write_count   (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREGS*WIDTH-1:0] flat;
    logic                   commit;
    logic [AW-1:0]          caddr;
    logic [15:0]            count;
  } exp_t;

  typedef struct {
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        expCommit;
    logic [4:0]  expAddr;
    logic [15:0] expCount;
  } vec_t;

  exp_t        sbQueue[$];
  logic [31:0] model[NREGS];
  logic        mCommit;
  logic [4:0]  mAddr;
  logic [15:0] mCount;
  int          errors = 0;
  int          checks = 0;

  // Rebuild the expected flat bus from the register model.
  function automatic logic [NREGS*WIDTH-1:0] modelFlat();
    logic [NREGS*WIDTH-1:0] f;
    f = '0;
    for (int i = 0; i < NREGS; i++) f[i*WIDTH +: WIDTH] = (i == ZR) ? 32'h0 : model[i];
    return f;
  endfunction

  // Drive one cycle of inputs at the falling edge, predict the result and queue it.
  task automatic applyStimulus(input logic rst, input logic rw, input logic [4:0] addr,
                               input logic [31:0] data);
    exp_t e;
    @(negedge clk);
    reset = rst; RegWrite = rw; WriteRegister = addr; WriteData = data;
    if (!rst && rw && addr != 5'(ZR)) begin
      #1;
      checks++;
      if (regs_flat[addr*WIDTH +: WIDTH] !== model[addr]) begin
        errors++;
        $display("[TB] FAIL same_cycle_old r%0d: got %h want %h", addr,
                 regs_flat[addr*WIDTH +: WIDTH], model[addr]);
      end
    end
    if (rst) begin
      for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
      mCommit = 1'b0; mAddr = '0; mCount = '0;
    end else if (rw && addr != 5'(ZR)) begin
      model[addr] = data;
      mCommit = 1'b1; mAddr = addr; mCount = mCount + 16'd1;
    end else begin
      mCommit = 1'b0;
    end
    e.flat = modelFlat(); e.commit = mCommit; e.caddr = mAddr; e.count = mCount;
    sbQueue.push_back(e);
  endtask

  // After the rising edge, pop the oldest prediction and compare all outputs.
  task automatic checkOutput(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    if (sbQueue.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s scoreboard_empty: got 0 entries want 1", tag);
      return;
    end
    e = sbQueue.pop_front();
    checks += 3;
    if (regs_flat !== e.flat) begin
      errors++;
      $display("[TB] FAIL %s regs_flat: got %h want %h", tag, regs_flat, e.flat);
    end
    if (wr_commit !== e.commit) begin
      errors++;
      $display("[TB] FAIL %s wr_commit: got %b want %b", tag, wr_commit, e.commit);
    end
    if (wr_commit_addr !== e.caddr) begin
      errors++;
      $display("[TB] FAIL %s wr_commit_addr: got %0d want %0d", tag, wr_commit_addr, e.caddr);
    end
    if (write_count !== e.count) begin
      errors++;
      $display("[TB] FAIL %s write_count: got %h want %h", tag, write_count, e.count);
    end
  endtask

  vec_t vecs[7];

  initial begin
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
    mCommit = 1'b0; mAddr = '0; mCount = '0;

    vecs[0] = '{1'b1, 5'd5,  32'h12345678, 1'b1, 5'd5, 16'd1};
    vecs[1] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd5, 16'd1};
    vecs[2] = '{1'b1, 5'd7,  32'h0000000A, 1'b1, 5'd7, 16'd2};
    vecs[3] = '{1'b1, 5'd7,  32'h0000000B, 1'b1, 5'd7, 16'd3};
    vecs[4] = '{1'b0, 5'd7,  32'h0000000C, 1'b0, 5'd7, 16'd3};
    vecs[5] = '{1'b0, 5'bx,  32'hCAFEF00D, 1'b0, 5'd7, 16'd3};
    vecs[6] = '{1'b1, 5'd0,  32'h00000055, 1'b1, 5'd0, 16'd4};

    // Reset held for two cycles while a write is presented.
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 1'b1, 5'd3, 32'hDEADBEEF);
      checkOutput("reset");
    end

    for (int v = 0; v < 7; v++) begin
      applyStimulus(1'b0, vecs[v].rw, vecs[v].addr, vecs[v].data);
      checkOutput($sformatf("vec%0d", v));
      checks += 3;
      if (wr_commit !== vecs[v].expCommit) begin
        errors++;
        $display("[TB] FAIL vec%0d tbl_commit: got %b want %b", v, wr_commit, vecs[v].expCommit);
      end
      if (wr_commit_addr !== vecs[v].expAddr) begin
        errors++;
        $display("[TB] FAIL vec%0d tbl_addr: got %0d want %0d", v, wr_commit_addr, vecs[v].expAddr);
      end
      if (write_count !== vecs[v].expCount) begin
        errors++;
        $display("[TB] FAIL vec%0d tbl_count: got %0d want %0d", v, write_count, vecs[v].expCount);
      end
    end
    checks++;
    if (regs_flat[7*WIDTH +: WIDTH] !== 32'hB) begin
      errors++;
      $display("[TB] FAIL overwrite_r7: got %h want %h", regs_flat[7*WIDTH +: WIDTH], 32'hB);
    end

    // Reset, then walk every writable register.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("walk_reset");
    for (int i = 0; i < 31; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101);
      checkOutput($sformatf("walk%0d", i));
    end
    checks += 2;
    if (write_count !== 16'd31) begin
      errors++;
      $display("[TB] FAIL walk_count: got %0d want %0d", write_count, 31);
    end
    if (regs_flat[30*WIDTH +: WIDTH] !== 32'h1E1E1E1E) begin
      errors++;
      $display("[TB] FAIL walk_r30: got %h want %h", regs_flat[30*WIDTH +: WIDTH], 32'h1E1E1E1E);
    end

    // Run the commit counter up to 16'hFFFF, then one more commit wraps it to 0.
    while (mCount != 16'hFFFF) begin
      applyStimulus(1'b0, 1'b1, 5'(mCount % 16'd31), $urandom);
      checkOutput("preload");
    end
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h99999999);
    checkOutput("wrap");
    checks++;
    if (write_count !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL wrap_count: got %h want %h", write_count, 16'h0000);
    end

    // Reset concurrent with a write to r2 drops the write; the next write lands.
    applyStimulus(1'b1, 1'b1, 5'd2, 32'h22222222);
    checkOutput("reset_mid");
    checks++;
    if (regs_flat !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_clear: got %h want 0", regs_flat);
    end
    applyStimulus(1'b0, 1'b1, 5'd2, 32'h77777777);
    checkOutput("post_reset");
    applyStimulus(1'b0, 1'b0, 5'd2, 32'h0);
    checkOutput("idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_bank.md
Name: regfile_write_bank

Overview:
- Storage half of the 32x32 register file.
- Holds 32 architectural 32-bit registers and decodes the single write port.
- Presents every register's current value in parallel to the downstream read-select mux stage, once per read port.
- Register 31 is the hardwired zero register: it always reads 0 and ignores writes.

Parameters:
- WIDTH, 32, data width of each register.
- NREGS, 32, number of registers; must equal 2**AW.
- AW, 5, write-address width.
- ZERO_REG, 31, index of the hardwired-zero register.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; clears all registers.
- RegWrite  input  1  write enable for this cycle.
- WriteRegister  input  AW  destination register index.
- WriteData  input  WIDTH  value to write.
- regs_flat  output  NREGS*WIDTH  all register values; bits [i*WIDTH +: WIDTH] = register i.
- wr_commit  output  1  registered; 1 for one cycle after a write that changed state.
- wr_commit_addr  output  AW  registered; index of the last committed write.
- write_count  output  16  registered; count of committed writes, wraps at 16'hFFFF -> 0.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: while reset is high at a clk edge, all registers become 0, wr_commit=0, wr_commit_addr=0, write_count=0. reset overrides a simultaneous RegWrite; no write lands that cycle.
- Write decode: 5-to-32 one-hot decode of WriteRegister, ANDed with RegWrite. Exactly one or zero enables asserted per cycle.
- Commit: at the rising edge with RegWrite=1 and WriteRegister!=ZERO_REG, register[WriteRegister] <= WriteData. The new value is visible on regs_flat after that edge, so write-to-visible latency is 1 cycle.
- Same-cycle read of the target: regs_flat shows the OLD value during the write cycle. There is no internal bypass; forwarding is the consumer's responsibility.
- Zero register: slice ZERO_REG of regs_flat is a constant 0, not a flop.
  - A write to ZERO_REG leaves all state unchanged.
  - It produces wr_commit=0 the next cycle and does not increment write_count.
- wr_commit / wr_commit_addr / write_count: updated at the same edge as the committing write. wr_commit is 0 in any cycle following an edge with no commit.
- Back-to-back writes to the same register: last-edge-wins. Each write counts as a commit.
- Held inputs: if RegWrite=0, WriteRegister and WriteData are don't-care and must not affect state.
- X-safety: an X on WriteRegister with RegWrite=0 must not corrupt any register.
- Reset mid-stream: a write presented in the same cycle as reset is dropped. The first post-reset write commits normally on the following edge.
- Combinational path: regs_flat is driven directly from the flops (plus the constant zero slice), with no logic between storage and output.

Decomposition:
- Shared package/header (regfile_defs): WIDTH, AW, NREGS, ZERO_REG constants. Shared with the read-mux stage so index width and zero-register index stay consistent.
- Sub-module: reg_en32, a WIDTH-bit register with synchronous active-high reset and write enable, instantiated NREGS-1 times via generate.
- The decoder is inline combinational logic within regfile_write_bank.

Test Plan:
- Reset: drive reset=1 for 2 cycles with RegWrite=1, WriteRegister=3, WriteData=32'hDEADBEEF -> all slices of regs_flat = 0, write_count=0, wr_commit=0.
- Basic write: RegWrite=1, WriteRegister=5, WriteData=32'h12345678 -> after the edge, slice 5 = 32'h12345678, all other slices 0, wr_commit=1, wr_commit_addr=5, write_count=1. During the write cycle itself, slice 5 still reads 0.
- Zero register: RegWrite=1, WriteRegister=31, WriteData=32'hFFFFFFFF -> slice 31 stays 0, wr_commit=0, write_count unchanged.
- Walk all registers: write value i*32'h01010101 to registers 0..30 on consecutive cycles -> every slice i equals its written value, slice 31 = 0, write_count=31.
- Overwrite and disabled write:
  - Write 32'hA to register 7, then 32'hB to register 7 on the next cycle -> slice 7 = 32'hB, write_count +2.
  - Then RegWrite=0 with WriteRegister=7, WriteData=32'hC -> slice 7 stays 32'hB, wr_commit=0.
- Reset mid-operation and counter wrap:
  - Preload write_count to 16'hFFFF via 65535 writes, then one more commit -> write_count=0.
  - Then assert reset for one cycle concurrent with a write to register 2 -> register 2 = 0 and all state cleared.
